// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V funct3
// size codes and the legality/alignment checks applied to every request.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_aligned(logic [2:0] funct3, logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return (addr_lo[0] == 1'b0);
            2'b10:   return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Stores only have the signed-size encodings; loads also allow lbu/lhu.
    function automatic logic is_legal(logic write, logic [2:0] funct3);
        if (write) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus the word-wide data memory port.
// master = core and memory side, slave = the load/store unit.
interface load_store_unit_if #(
    parameter int address_width = 32,
    parameter int word_width    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [2:0]               req_funct3;
    logic [address_width-1:0] req_address;
    logic [word_width-1:0]    req_write_data;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [word_width-1:0]    resp_read_data;
    logic                     resp_error;
    logic [address_width-1:0] mem_address;
    logic                     mem_write_enable;
    logic [word_width-1:0]    mem_write_data;
    logic [word_width-1:0]    mem_read_data;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_write_data,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_read_data, resp_error,
        input  mem_address, mem_write_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_write_data,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_read_data, resp_error,
        output mem_address, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/byte_lane_align.sv
// Combinational lane steering: extracts and extends a load lane, and merges
// sub-word store data into the previously read word.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;

    // Halfwords are aligned, so shifting by the byte offset lands them at bit 0.
    always_comb begin
        shifted   = read_word >> {addr_lo, 3'b000};
        load_data = read_word;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = read_word;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_sel;
            logic [7:0] lane_src;

            always_comb begin
                lane_sel = 1'b1;
                lane_src = store_data[8*gi +: 8];
                case (funct3[1:0])
                    2'b00: begin
                        lane_sel = (addr_lo == 2'(gi));
                        lane_src = store_data[7:0];
                    end
                    2'b01: begin
                        lane_sel = (addr_lo[1] == 1'(gi / 2));
                        lane_src = store_data[8*(gi % 2) +: 8];
                    end
                    default: ;
                endcase
            end

            assign merged_word[8*gi +: 8] = lane_sel ? lane_src : read_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, read-modify-write for sub-word
// stores, sign/zero-extended loads and a per-request misalignment error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int address_width = 32,
    parameter int word_width    = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    lsu_state_t               state_q, state_d;
    logic                     write_q, write_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [1:0]               addr_lo_q, addr_lo_d;
    logic [word_width-1:0]    wdata_q, wdata_d;
    logic [word_width-1:0]    resp_data_q, resp_data_d;
    logic                     resp_error_q, resp_error_d;
    logic [address_width-1:0] mem_address_q, mem_address_d;
    logic [word_width-1:0]    mem_write_data_q, mem_write_data_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        accept;
    logic        req_bad;

    byte_lane_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_lo_q),
        .read_word   (bus.mem_read_data),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign req_bad = !is_legal(bus.req_write, bus.req_funct3) ||
                     !is_aligned(bus.req_funct3, bus.req_address[1:0]);

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        funct3_d         = funct3_q;
        addr_lo_d        = addr_lo_q;
        wdata_d          = wdata_q;
        resp_data_d      = resp_data_q;
        resp_error_d     = resp_error_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d      = bus.req_write;
                    funct3_d     = bus.req_funct3;
                    addr_lo_d    = bus.req_address[1:0];
                    wdata_d      = bus.req_write_data;
                    resp_data_d  = '0;
                    resp_error_d = 1'b0;
                    if (req_bad) begin
                        resp_error_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mem_address_d = {bus.req_address[address_width-1:2], 2'b00};
                        if (bus.req_write && (bus.req_funct3 == F3_W)) begin
                            mem_write_data_d = bus.req_write_data;
                            state_d          = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    mem_write_data_d = merged_word;
                    state_d          = WRITE;
                end else begin
                    resp_data_d = load_data;
                    state_d     = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            wdata_q          <= '0;
            resp_data_q      <= '0;
            resp_error_q     <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            funct3_q         <= funct3_d;
            addr_lo_q        <= addr_lo_d;
            wdata_q          <= wdata_d;
            resp_data_q      <= resp_data_d;
            resp_error_q     <= resp_error_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign bus.req_ready        = (state_q == IDLE);
    assign bus.resp_valid       = (state_q == RESP);
    assign bus.resp_read_data   = resp_data_q;
    assign bus.resp_error       = resp_error_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_enable = (state_q == WRITE);
    assign bus.mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a byte-array
// reference memory with arithmetic sign extension.
module tb_load_store_unit;

    logic clock;
    logic reset_n;

    load_store_unit_if #(.address_width(32), .word_width(32)) bus ();

    load_store_unit #(.address_width(32), .word_width(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];
    logic [7:0]  ref_bytes [256];
    int          we_count = 0;
    logic [31:0] last_we_addr = '0;
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    assign bus.mem_read_data = mem[bus.mem_address[7:2]];

    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (bus.mem_write_enable === 1'b1) begin
            mem[bus.mem_address[7:2]] <= bus.mem_write_data;
            we_count     <= we_count + 1;
            last_we_addr <= bus.mem_address;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'(a[7:2]) * 4;
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    function automatic bit ref_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int n;
        legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = 1 << f3[1:0];
        return !legal || ((int'(a[7:0]) % n) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        longint v;
        n = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_bytes[int'(a[7:0]) + i]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_bytes[int'(a[7:0]) + i] = 8'(d >> (8 * i));
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] word);
        pre_we   = 1'b1;
        pre_idx  = a[7:2];
        pre_data = word;
        for (int i = 0; i < 4; i++) ref_bytes[int'(a[7:2]) * 4 + i] = 8'(word >> (8 * i));
        @(posedge clock);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_error"}, 32'(bus.resp_error), 32'd0);
        chk({tag, "_resp_data"}, bus.resp_read_data, 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_write_enable), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_address, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
    endtask

    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        bit          exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_data;
        int          lat;
        int          we0;
        logic [31:0] word_before;

        exp_err  = ref_err(w, f3, a);
        exp_lat  = exp_err ? 1 : (!w ? 2 : ((f3 == 3'b010) ? 2 : 3));
        exp_data = (exp_err || w) ? 32'd0 : ref_load(f3, a);
        exp_we   = (!exp_err && w) ? 1 : 0;
        word_before = ref_word(a);

        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        we0 = we_count;
        bus.req_valid      = 1'b1;
        bus.req_write      = w;
        bus.req_funct3     = f3;
        bus.req_address    = a;
        bus.req_write_data = wd;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_data", bus.resp_read_data, exp_data);
        chk("resp_error", 32'(bus.resp_error), 32'(exp_err));
        if (exp_we == 1) ref_store(f3, a, wd);

        for (int i = 0; i < hold; i++) begin
            bus.req_valid   = 1'b1;
            bus.req_write   = 1'b1;
            bus.req_funct3  = 3'b010;
            bus.req_address = 32'h0000_0040;
            @(posedge clock);
            #1;
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_data", bus.resp_read_data, exp_data);
            chk("hold_error", 32'(bus.resp_error), 32'(exp_err));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        chk("released", 32'(bus.resp_valid), 32'd0);
        chk("ready_back", 32'(bus.req_ready), 32'd1);
        chk("we_count", 32'(we_count - we0), 32'(exp_we));
        if (exp_we == 1) chk("we_addr", last_we_addr, {a[31:2], 2'b00});
        chk("mem_word", mem[a[7:2]], ref_word(a));
        $display("txn w=%0d f3=%0d addr=%h wdata=%h -> lat=%0d data=%h err=%0d word %h->%h",
                 w, f3, a, wd, lat, bus.resp_read_data, exp_err, word_before, ref_word(a));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          we0;
        logic [31:0] word20;
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;

        reset_n            = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_funct3     = 3'b000;
        bus.req_address    = '0;
        bus.req_write_data = '0;
        bus.resp_ready     = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        preload(32'h10, 32'h8899AABB);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h12, 32'h00001234, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'h11, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h15, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 3);

        we0    = we_count;
        word20 = ref_word(32'h20);
        bus.req_valid      = 1'b1;
        bus.req_write      = 1'b1;
        bus.req_funct3     = 3'b000;
        bus.req_address    = 32'h21;
        bus.req_write_data = 32'h77;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        reset_n       = 1'b0;
        @(posedge clock);
        #1;
        chk_reset_outputs("midreset");
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("midreset_no_write", 32'(we_count - we0), 32'd0);
        chk("midreset_word20", mem[8], word20);
        $display("txn sb addr=00000021 aborted by reset, word20=%h", mem[8]);

        do_req(1'b0, 3'b011, 32'h00, 32'h0, 0);

        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            do_req(w, f3, a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access controller between the core's execute stage and the word-addressed data_memory.
- Accepts one load/store request at a time and drives the word-wide memory port: address, write_enable, write_data, and the combinational read_data.
- Implements RISC-V byte/halfword/word semantics:
  - sub-word stores by read-modify-write;
  - loads extract the addressed lane and sign- or zero-extend it.
- Detects misalignment and reports a per-request error.

Parameters:
- address_width, 32, byte address width on both core and memory sides.
- word_width, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V size/sign code.
- req_address  input  address_width  byte address.
- req_write_data  input  word_width  store data, right-justified.
- resp_valid  output  1  response available.
- resp_ready  input  1  core consumes the response.
- resp_read_data  output  word_width  extended load result; 0 for stores and errors.
- resp_error  output  1  misaligned address or illegal funct3.
- mem_address  output  address_width  word-aligned address; bits [1:0] always 0.
- mem_write_enable  output  1  one-cycle write strobe.
- mem_write_data  output  word_width  full word to write.
- mem_read_data  input  word_width  combinational read of mem_address.

Behaviour:
- States: IDLE, READ, WRITE, RESP. An accept is req_valid && req_ready.
- Reset: applies when reset_n=0 at posedge and wins over every other event. Results:
  - state=IDLE;
  - req_ready=1 after reset;
  - resp_valid=0, resp_error=0, resp_read_data=0;
  - mem_write_enable=0, mem_address=0, mem_write_data=0.
  - Reset mid-operation: any in-flight request is dropped and no write is issued afterwards.
- funct3 legality:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu;
  - stores: 000 sb, 001 sh, 010 sw;
  - all other codes are illegal.
- Alignment: halfword needs address[0]=0; word needs address[1:0]=00.
- IDLE, on accept: latch the request.
  - Illegal or misaligned → RESP with error=1 and no memory activity.
  - Otherwise → READ, except sw, which → WRITE.
- READ (1 cycle):
  - drive mem_address = {address[31:2],2'b00};
  - capture mem_read_data into the data register at the clock edge.
  - Load → RESP, with resp_read_data = the extracted and extended lane.
  - Sub-word store → WRITE.
- WRITE (1 cycle):
  - mem_write_enable=1 for exactly this cycle.
  - mem_write_data: sw → req_write_data; sb/sh → the captured word with the addressed lane(s) replaced.
  - → RESP.
- RESP: resp_valid=1, with data and error stable while resp_valid=1 && resp_ready=0.
  - On resp_ready → IDLE.
  - req_ready=0 throughout, so there are no back-to-back accepts.
- Latency, counting from the accept edge:
  - load: resp_valid in cycle 2;
  - sw: resp_valid in cycle 2;
  - sb/sh: resp_valid in cycle 3;
  - error: resp_valid in cycle 1.
- Lanes are little-endian: byte k = bits [8k+7:8k]; halfword at address[1]=1 uses bits [31:16].
- Outside READ/WRITE, mem_address holds its last value and mem_write_enable=0.

Decomposition:
- lsu_pkg holds:
  - typedef enum lsu_state_t {IDLE, READ, WRITE, RESP};
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the function is_aligned(funct3, addr[1:0]).
- Sub-module byte_lane_align (combinational) performs:
  - load extract plus sign/zero extend;
  - store merge of the new lane(s) into the old word.
- This keeps the FSM file focused on sequencing.

Test Plan:
1. Preload the word at 0x10 = 0x8899AABB, then issue lb @0x13 → resp in cycle 2 with resp_read_data=0xFFFFFF88, error=0, and mem_write_enable never high. Repeat as lbu → 0x00000088.
2. sh 0x00001234 @0x12 on that word → exactly one mem_write_enable cycle (cycle 2) at mem_address=0x10 with mem_write_data=0x1234AABB. resp_valid in cycle 3, resp_read_data=0. A following lw @0x10 returns 0x1234AABB.
3. lw @0x11 and lh @0x15 → resp_valid in cycle 1 with error=1 and resp_read_data=0. No mem_write_enable; memory is unchanged.
4. sw 0xDEADBEEF @0x20 with resp_ready held low for 3 cycles → resp_valid, data and error held stable. req_ready stays 0, and req_valid is ignored until the cycle after resp_ready=1.
5. sb 0x77 @0x21 with reset_n=0 asserted during the READ cycle → no mem_write_enable at any point. All outputs read their reset values next cycle, and the word at 0x20 is unchanged.
6. Illegal funct3=011 load @0x00 → error=1 with no memory access.
